// File: rtl/scarv_cop_sha3_agen.sv
// ----------------------------------------------------------------------------
// scarv_cop_sha3_agen
//   Keccak lane address generator. One request (mode, x, y, base) becomes a
//   stream of lane addresses base + (index << LANE_SHIFT), index = x + 5*y.
//   Single modes emit one beat; sweep modes walk the full state (linear or
//   pi order) or one column.
//
// Optional feature macro: SCARV_COP_SHA3_AGEN_PIPE_EN
//   When defined, a new request may be accepted in the same cycle as the
//   final beat handshake, removing the idle bubble between streams.
//
// Ports:
//   g_clk, g_reset          clock, asynchronous active-high reset
//   req_valid/req_ready     request handshake
//   req_mode                0 XY,1 X1,2 X2,3 X4,4 YX,5 LIN,6 PI,7 COL
//   req_x, req_y            lane coordinates (reduced mod 5)
//   req_base                state base address
//   req_flush               abort current stream (beats a same-cycle request)
//   out_valid/out_ready     beat handshake
//   out_addr, out_index     lane address / lane index
//   out_last                final beat of the request
//   busy                    FSM in RUN
// ----------------------------------------------------------------------------
module scarv_cop_sha3_agen #(
  parameter int unsigned LANE_SHIFT = 3,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              g_clk,
  input  logic              g_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_mode,
  input  logic [2:0]        req_x,
  input  logic [2:0]        req_y,
  input  logic [ADDR_W-1:0] req_base,
  input  logic              req_flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [4:0]        out_index,
  output logic              out_last,
  output logic              busy
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  typedef enum logic [2:0] {
    M_XY  = 3'd0,
    M_X1  = 3'd1,
    M_X2  = 3'd2,
    M_X4  = 3'd3,
    M_YX  = 3'd4,
    M_LIN = 3'd5,
    M_PI  = 3'd6,
    M_COL = 3'd7
  } mode_t;

  // mod 5 for values 0..20 by comparison, no divider
  function automatic logic [2:0] mod5(input logic [4:0] v);
    logic [2:0] r;
    if      (v >= 5'd20) r = 3'(v - 5'd20);
    else if (v >= 5'd15) r = 3'(v - 5'd15);
    else if (v >= 5'd10) r = 3'(v - 5'd10);
    else if (v >= 5'd5)  r = 3'(v - 5'd5);
    else                 r = 3'(v);
    return r;
  endfunction

  function automatic logic [4:0] times5(input logic [2:0] v);
    return {v, 2'b00} + {2'b00, v};
  endfunction

  // (2a + 3b) mod 5, the pi-permutation row term
  function automatic logic [2:0] pi_row(input logic [2:0] a, input logic [2:0] b);
    return mod5({1'b0, a, 1'b0} + {1'b0, b, 1'b0} + {2'b00, b});
  endfunction

  function automatic logic [4:0] lane_index(
    input mode_t      m,
    input logic [2:0] x,
    input logic [2:0] y,
    input logic [2:0] cx,
    input logic [2:0] cy
  );
    logic [4:0] idx;
    unique case (m)
      M_XY:  idx = {2'b00, x} + times5(y);
      M_X1:  idx = {2'b00, mod5({2'b00, x} + 5'd1)} + times5(y);
      M_X2:  idx = {2'b00, mod5({2'b00, x} + 5'd2)} + times5(y);
      M_X4:  idx = {2'b00, mod5({2'b00, x} + 5'd4)} + times5(y);
      M_YX:  idx = {2'b00, y} + times5(pi_row(x, y));
      M_LIN: idx = {2'b00, cx} + times5(cy);
      M_PI:  idx = {2'b00, cy} + times5(pi_row(cx, cy));
      M_COL: idx = {2'b00, x} + times5(cy);
    endcase
    return idx;
  endfunction

  function automatic logic beat_last(
    input mode_t      m,
    input logic [2:0] cx,
    input logic [2:0] cy
  );
    logic l;
    unique case (m)
      M_LIN, M_PI: l = (cx == 3'd4) && (cy == 3'd4);
      M_COL:       l = (cy == 3'd4);
      default:     l = 1'b1;
    endcase
    return l;
  endfunction

  function automatic logic [ADDR_W-1:0] lane_addr(
    input logic [ADDR_W-1:0] base,
    input logic [4:0]        idx
  );
    return base + (ADDR_W'(idx) << LANE_SHIFT);
  endfunction

  state_t              state_q, state_d;
  mode_t               mode_q, mode_d;
  logic [2:0]          x_q, x_d, y_q, y_d;
  logic [2:0]          cx_q, cx_d, cy_q, cy_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [4:0]          index_q, index_d;
  logic                last_q, last_d;

  logic                beat_hs;
  logic                req_fire;
  mode_t               req_m;
  logic [2:0]          req_xr, req_yr;
  logic [4:0]          first_idx, next_idx;
  logic [2:0]          cx_n, cy_n;

  assign beat_hs = valid_q && out_ready;

`ifdef SCARV_COP_SHA3_AGEN_PIPE_EN
  assign req_ready = (state_q == ST_IDLE) ||
                     ((state_q == ST_RUN) && beat_hs && last_q);
`else
  assign req_ready = (state_q == ST_IDLE);
`endif

  assign req_fire = req_valid && req_ready && !req_flush;

  always_comb begin
    req_m     = mode_t'(req_mode);
    req_xr    = mod5({2'b00, req_x});
    req_yr    = mod5({2'b00, req_y});
    first_idx = lane_index(req_m, req_xr, req_yr, 3'd0, 3'd0);

    // column sweep only steps cy; full sweeps step cx fastest
    cx_n = cx_q;
    cy_n = cy_q;
    if (mode_q == M_COL) begin
      cy_n = (cy_q == 3'd4) ? 3'd0 : cy_q + 3'd1;
    end else begin
      cx_n = (cx_q == 3'd4) ? 3'd0 : cx_q + 3'd1;
      if (cx_q == 3'd4) cy_n = (cy_q == 3'd4) ? 3'd0 : cy_q + 3'd1;
    end
    next_idx = lane_index(mode_q, x_q, y_q, cx_n, cy_n);
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    base_d  = base_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    index_d = index_q;
    last_d  = last_q;

    if (req_flush) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
    end else if (req_fire) begin
      state_d = ST_RUN;
      mode_d  = req_m;
      x_d     = req_xr;
      y_d     = req_yr;
      base_d  = req_base;
      cx_d    = 3'd0;
      cy_d    = 3'd0;
      valid_d = 1'b1;
      index_d = first_idx;
      addr_d  = lane_addr(req_base, first_idx);
      last_d  = beat_last(req_m, 3'd0, 3'd0);
    end else if ((state_q == ST_RUN) && beat_hs) begin
      if (last_q) begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end else begin
        cx_d    = cx_n;
        cy_d    = cy_n;
        index_d = next_idx;
        addr_d  = lane_addr(base_q, next_idx);
        last_d  = beat_last(mode_q, cx_n, cy_n);
      end
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q <= ST_IDLE;
      mode_q  <= M_XY;
      x_q     <= '0;
      y_q     <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      base_q  <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      base_q  <= base_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      index_q <= index_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_addr  = addr_q;
  assign out_index = index_q;
  assign out_last  = last_q;
  assign busy      = (state_q == ST_RUN);

endmodule

// File: tb/tb_scarv_cop_sha3_agen.sv
// ----------------------------------------------------------------------------
// tb_scarv_cop_sha3_agen
//   Scoreboard bench for scarv_cop_sha3_agen: expected beats are queued when
//   a request is accepted and compared as the DUT presents them.
// ----------------------------------------------------------------------------
module tb_scarv_cop_sha3_agen;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_mode;
  logic [2:0]  req_x;
  logic [2:0]  req_y;
  logic [31:0] req_base;
  logic        req_flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [4:0]  out_index;
  logic        out_last;
  logic        busy;

  scarv_cop_sha3_agen #(
    .LANE_SHIFT(3),
    .ADDR_W    (32)
  ) dut (
    .g_clk    (g_clk),
    .g_reset  (g_reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_mode (req_mode),
    .req_x    (req_x),
    .req_y    (req_y),
    .req_base (req_base),
    .req_flush(req_flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr (out_addr),
    .out_index(out_index),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 g_clk = ~g_clk;

  typedef struct {
    int unsigned idx;
    logic [31:0] addr;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    pop_count = 0;
  int    pop_cyc = 0;
  int    pop_cyc_prev = 0;

  always @(posedge g_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference lane sequence built from plain % arithmetic
  task automatic push_exp(input int m, input int x, input int y, input logic [31:0] base);
    int xm = x % 5;
    int ym = y % 5;
    int idxs[$];
    beat_t b;
    case (m)
      0: idxs.push_back(xm + 5 * ym);
      1: idxs.push_back((xm + 1) % 5 + 5 * ym);
      2: idxs.push_back((xm + 2) % 5 + 5 * ym);
      3: idxs.push_back((xm + 4) % 5 + 5 * ym);
      4: idxs.push_back(ym + 5 * ((2 * xm + 3 * ym) % 5));
      5: for (int cy = 0; cy < 5; cy++)
           for (int cx = 0; cx < 5; cx++) idxs.push_back(cx + 5 * cy);
      6: for (int cy = 0; cy < 5; cy++)
           for (int cx = 0; cx < 5; cx++) idxs.push_back(cy + 5 * ((2 * cx + 3 * cy) % 5));
      default: for (int cy = 0; cy < 5; cy++) idxs.push_back(xm + 5 * cy);
    endcase
    for (int i = 0; i < idxs.size(); i++) begin
      b.idx  = idxs[i];
      b.addr = base + 32'(idxs[i] * 8);
      b.last = (i == idxs.size() - 1);
      exp_q.push_back(b);
    end
  endtask

  // Compare the presented beat against the queue head every cycle it is
  // valid, so stalled beats are also checked for stability.
  always @(negedge g_clk) begin
    if (!g_reset && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexp_beat", {31'b0, out_valid}, 32'd0);
      end else begin
        chk("index", {27'b0, out_index}, exp_q[0].idx);
        chk("addr", out_addr, exp_q[0].addr);
        chk("last", {31'b0, out_last}, {31'b0, exp_q[0].last});
        if (out_ready) begin
          void'(exp_q.pop_front());
          pop_count++;
          pop_cyc_prev = pop_cyc;
          pop_cyc = cyc;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_req(input int m, input int x, input int y, input logic [31:0] base);
    logic rdy;
    bit   done = 0;
    req_valid = 1'b1;
    req_mode  = 3'(m);
    req_x     = 3'(x);
    req_y     = 3'(y);
    req_base  = base;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge g_clk);
      rdy = req_ready;
      @(posedge g_clk);
      if (rdy) begin
        push_exp(m, x, y, base);
        done = 1;
      end
    end
    #1;
    req_valid = 1'b0;
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input bit toggle);
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge g_clk);
      #1;
      if (exp_q.size() == 0) done = 1;
      else if (toggle) out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    if (!done) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge g_clk);
      #1;
    end
  endtask

  initial begin
    int p0;
    bit ok;
    g_reset   = 1'b1;
    req_valid = 1'b0;
    req_mode  = '0;
    req_x     = '0;
    req_y     = '0;
    req_base  = '0;
    req_flush = 1'b0;
    out_ready = 1'b1;
    cycles(2);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_addr", out_addr, 32'd0);
    chk("rst_index", {27'b0, out_index}, 32'd0);
    chk("rst_last", {31'b0, out_last}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    g_reset = 1'b0;
    cycles(1);

    // single modes
    send_req(0, 6, 2, 32'h1000);
    drain(0);
    chk("xy_idle_ready", {31'b0, req_ready}, 32'd1);
    chk("xy_idle_busy", {31'b0, busy}, 32'd0);
    chk("xy_idle_valid", {31'b0, out_valid}, 32'd0);
    send_req(4, 1, 2, 32'h1000);
    drain(0);
    send_req(3, 3, 0, 32'h1000);
    drain(0);
    send_req(1, 4, 7, 32'h2000);
    drain(0);
    send_req(2, 7, 3, 32'h2000);
    drain(0);

    // linear sweep with out_ready toggling
    p0 = pop_count;
    send_req(5, 0, 0, 32'h1000);
    drain(1);
    chk("lin_beats", 32'(pop_count - p0), 32'd25);

    // pi sweep
    p0 = pop_count;
    send_req(6, 2, 3, 32'h1000);
    drain(0);
    chk("pi_beats", 32'(pop_count - p0), 32'd25);

    // flush on beat 7 with a competing request in the same cycle
    p0 = pop_count;
    send_req(5, 0, 0, 32'h1000);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (pop_count - p0 == 7) ok = 1;
      else cycles(1);
    end
    if (!ok) chk("flush_wait_timeout", 32'd0, 32'd1);
    out_ready = 1'b0;
    req_flush = 1'b1;
    req_valid = 1'b1;
    req_mode  = 3'd0;
    req_x     = 3'd1;
    req_y     = 3'd1;
    @(posedge g_clk);
    #1;
    req_flush = 1'b0;
    req_valid = 1'b0;
    exp_q.delete();
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_ready", {31'b0, req_ready}, 32'd1);
    chk("flush_busy", {31'b0, busy}, 32'd0);
    out_ready = 1'b1;
    cycles(4);
    chk("flush_quiet", {31'b0, out_valid}, 32'd0);

    // asynchronous reset mid-sweep
    p0 = pop_count;
    send_req(6, 0, 0, 32'h1000);
    cycles(5);
    g_reset = 1'b1;
    #1;
    exp_q.delete();
    chk("mrst_valid", {31'b0, out_valid}, 32'd0);
    chk("mrst_addr", out_addr, 32'd0);
    chk("mrst_index", {27'b0, out_index}, 32'd0);
    chk("mrst_last", {31'b0, out_last}, 32'd0);
    chk("mrst_busy", {31'b0, busy}, 32'd0);
    @(posedge g_clk);
    #1;
    g_reset = 1'b0;
    cycles(4);
    chk("mrst_quiet", {31'b0, out_valid}, 32'd0);

    // column sweep with address wrap
    send_req(7, 0, 4, 32'hFFFF_FFF8);
    drain(0);

    // back-to-back single requests
    send_req(0, 2, 2, 32'h3000);
    send_req(1, 2, 2, 32'h3000);
    drain(0);
`ifdef SCARV_COP_SHA3_AGEN_PIPE_EN
    chk("b2b_gap", 32'(pop_cyc - pop_cyc_prev), 32'd1);
`else
    chk("b2b_gap", 32'(pop_cyc - pop_cyc_prev), 32'd2);
`endif

    cycles(2);
    chk("final_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
